// File: rtl/mem_port_arbiter_if.sv
// Main-memory beat port shared by the I- and D-cache miss paths.
// The arbiter drives the request side; memory drives rdata/ready.
// The caches read mem_rdata straight off this bundle (no register in between).
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache line fills and
// D-cache line fills / single-word writes. Fills are line-aligned bursts.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 4,
    localparam int unsigned BEAT_W   = $clog2(BURST_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic [BEAT_W-1:0] fill_idx,
    output logic              stall_f,
    output logic              stall_m,
    mem_port_arbiter_if.master mem
);

    localparam logic [ADDR_W-1:0] LineMask = ~ADDR_W'(BURST_LEN * 4 - 1);
    localparam logic [ADDR_W-1:0] WordMask = ~ADDR_W'(3);
    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;
    typedef enum logic {OwnerI, OwnerD} owner_e;

    state_e            state_q;
    owner_e            owner_q;
    owner_e            last_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [BEAT_W-1:0] beat_q;

    logic   grant_any;
    owner_e winner;

    // Pick the winner: on a tie, whoever did not own the port last time.
    always_comb begin
        grant_any = i_req | d_req;
        if (d_req && (!i_req || last_q == OwnerI)) begin
            winner = OwnerD;
        end else begin
            winner = OwnerI;
        end
    end

    // Transaction FSM with registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            owner_q     <= OwnerI;
            last_q      <= OwnerI;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            beat_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        owner_q   <= winner;
                        last_q    <= winner;
                        mem_req_q <= 1'b1;
                        if (winner == OwnerD && d_we) begin
                            state_q     <= StWrite;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= d_addr & WordMask;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            state_q    <= StRead;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= ((winner == OwnerD) ? d_addr : i_addr) & LineMask;
                            beat_q     <= '0;
                        end
                    end
                end
                StRead: begin
                    if (mem.mem_ready) begin
                        // Power-of-2 burst: the counter wraps back to 0 on the last beat.
                        beat_q     <= beat_q + 1'b1;
                        mem_addr_q <= mem_addr_q + ADDR_W'(4);
                        if (beat_q == LastBeat) begin
                            mem_req_q <= 1'b0;
                            state_q   <= StDone;
                        end
                    end
                end
                StWrite: begin
                    if (mem.mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign i_rvalid = (state_q == StRead) && mem.mem_ready && (owner_q == OwnerI);
    assign d_rvalid = (state_q == StRead) && mem.mem_ready && (owner_q == OwnerD);
    assign i_done   = (state_q == StDone) && (owner_q == OwnerI);
    assign d_done   = (state_q == StDone) && (owner_q == OwnerD);
    assign fill_idx = beat_q;

    assign stall_f = i_req & ~i_done;
    assign stall_m = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand
// sequences for arbitration order, back-pressure and mid-burst reset.
module tb_mem_port_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_rvalid, i_done, d_rvalid, d_done;
    logic [1:0]  fill_idx;
    logic        stall_f, stall_m;

    int n_chk = 0;
    int n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rvalid (i_rvalid),
        .i_done   (i_done),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rvalid (d_rvalid),
        .d_done   (d_done),
        .fill_idx (fill_idx),
        .stall_f  (stall_f),
        .stall_m  (stall_m),
        .mem      (mem_bus)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus and expected outputs. ck gates the we/addr check;
    // wdata is compared only when a write is expected on the bus.
    typedef struct {
        logic        ir, dr, we, rdy;
        logic [31:0] addr, wd;
        logic        ck, er, ewe;
        logic [31:0] ea, ewd;
        logic        irv, drv, idn, ddn;
        logic [1:0]  idx;
        logic        sf, sm;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Raise the chosen requests together (D as reads) and record the done order.
    task automatic serve(input logic ri, input logic rd, input string exp);
        string got;
        int    cyc;
        int    both;
        got  = "";
        cyc  = 0;
        both = 0;
        @(negedge clk);
        i_req = ri; d_req = rd; d_we = 1'b0; mem_bus.mem_ready = 1'b1;
        i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
        while ((i_req || d_req) && cyc < 40) begin
            #1;
            if ((i_done && d_done) || (i_rvalid && d_rvalid)) both++;
            if (i_done) begin got = {got, "I"}; i_req = 1'b0; end
            if (d_done) begin got = {got, "D"}; d_req = 1'b0; end
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL grant order: got \"%s\", want \"%s\"", got, exp);
        end
        chk("exclusive rvalid/done", 32'(both), 32'd0);
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int wait_cyc;
        logic seen;

        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = Z; d_addr = Z; d_wdata = Z;
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 32'hA5A5_0000;

        // I fill at 0x1234, ready tied high
        tbl.push_back('{H,L,L,H,32'h1234,Z, L,L,L,Z,Z, L,L,L,L,2'd0,H,L});
        tbl.push_back('{H,L,L,H,32'h1234,Z, H,H,L,32'h1230,Z, H,L,L,L,2'd0,H,L});
        tbl.push_back('{H,L,L,H,32'h1234,Z, H,H,L,32'h1234,Z, H,L,L,L,2'd1,H,L});
        tbl.push_back('{H,L,L,H,32'h1234,Z, H,H,L,32'h1238,Z, H,L,L,L,2'd2,H,L});
        tbl.push_back('{H,L,L,H,32'h1234,Z, H,H,L,32'h123C,Z, H,L,L,L,2'd3,H,L});
        tbl.push_back('{H,L,L,H,32'h1234,Z, L,L,L,Z,Z, L,L,H,L,2'd0,L,L});
        tbl.push_back('{L,L,L,H,32'h1234,Z, L,L,L,Z,Z, L,L,L,L,2'd0,L,L});
        // D write 0x103 with three wait cycles
        tbl.push_back('{L,H,H,L,32'h103,32'hDEADBEEF, L,L,L,Z,Z, L,L,L,L,2'd0,L,H});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{L,H,H,L,32'h103,32'hDEADBEEF,
                            H,H,H,32'h100,32'hDEADBEEF, L,L,L,L,2'd0,L,H});
        tbl.push_back('{L,H,H,H,32'h103,32'hDEADBEEF,
                        H,H,H,32'h100,32'hDEADBEEF, L,L,L,L,2'd0,L,H});
        tbl.push_back('{L,H,H,H,32'h103,32'hDEADBEEF, L,L,L,Z,Z, L,L,L,H,2'd0,L,L});
        tbl.push_back('{L,L,L,H,32'h103,Z, L,L,L,Z,Z, L,L,L,L,2'd0,L,L});
        // D fill 0x200C with two wait cycles at beat 2
        tbl.push_back('{L,H,L,H,32'h200C,Z, L,L,L,Z,Z, L,L,L,L,2'd0,L,H});
        tbl.push_back('{L,H,L,H,32'h200C,Z, H,H,L,32'h2000,Z, L,H,L,L,2'd0,L,H});
        tbl.push_back('{L,H,L,H,32'h200C,Z, H,H,L,32'h2004,Z, L,H,L,L,2'd1,L,H});
        tbl.push_back('{L,H,L,L,32'h200C,Z, H,H,L,32'h2008,Z, L,L,L,L,2'd0,L,H});
        tbl.push_back('{L,H,L,L,32'h200C,Z, H,H,L,32'h2008,Z, L,L,L,L,2'd0,L,H});
        tbl.push_back('{L,H,L,H,32'h200C,Z, H,H,L,32'h2008,Z, L,H,L,L,2'd2,L,H});
        tbl.push_back('{L,H,L,H,32'h200C,Z, H,H,L,32'h200C,Z, L,H,L,L,2'd3,L,H});
        tbl.push_back('{L,H,L,H,32'h200C,Z, L,L,L,Z,Z, L,L,L,H,2'd0,L,L});
        tbl.push_back('{L,L,L,H,32'h200C,Z, L,L,L,Z,Z, L,L,L,L,2'd0,L,L});
        // Back-to-back writes: req dropped in the done cycle, re-raised next cycle
        tbl.push_back('{L,H,H,H,32'h40,32'h1111_1111, L,L,L,Z,Z, L,L,L,L,2'd0,L,H});
        tbl.push_back('{L,H,H,H,32'h40,32'h1111_1111,
                        H,H,H,32'h40,32'h1111_1111, L,L,L,L,2'd0,L,H});
        tbl.push_back('{L,L,H,H,32'h40,32'h1111_1111, L,L,L,Z,Z, L,L,L,H,2'd0,L,L});
        tbl.push_back('{L,H,H,H,32'h44,32'h2222_2222, L,L,L,Z,Z, L,L,L,L,2'd0,L,H});
        tbl.push_back('{L,H,H,H,32'h44,32'h2222_2222,
                        H,H,H,32'h44,32'h2222_2222, L,L,L,L,2'd0,L,H});
        tbl.push_back('{L,L,H,H,32'h44,32'h2222_2222, L,L,L,Z,Z, L,L,L,H,2'd0,L,L});
        tbl.push_back('{L,L,L,H,Z,Z, L,L,L,Z,Z, L,L,L,L,2'd0,L,L});
        tbl.push_back('{L,L,L,H,Z,Z, L,L,L,Z,Z, L,L,L,L,2'd0,L,L});

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_bus.mem_we), 32'd0);
        chk("rst mem_addr", mem_bus.mem_addr, Z);
        chk("rst mem_wdata", mem_bus.mem_wdata, Z);
        chk("rst fill_idx", 32'(fill_idx), 32'd0);
        chk("rst rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        chk("rst done", 32'({i_done, d_done}), 32'd0);
        chk("rst stall", 32'({stall_f, stall_m}), 32'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            i_req = tbl[i].ir; d_req = tbl[i].dr; d_we = tbl[i].we;
            mem_bus.mem_ready = tbl[i].rdy;
            i_addr = tbl[i].addr; d_addr = tbl[i].addr; d_wdata = tbl[i].wd;
            #1;
            chk($sformatf("v%0d mem_req", i), 32'(mem_bus.mem_req), 32'(tbl[i].er));
            if (tbl[i].ck) begin
                chk($sformatf("v%0d mem_we", i), 32'(mem_bus.mem_we), 32'(tbl[i].ewe));
                chk($sformatf("v%0d mem_addr", i), mem_bus.mem_addr, tbl[i].ea);
                if (tbl[i].ewe)
                    chk($sformatf("v%0d mem_wdata", i), mem_bus.mem_wdata, tbl[i].ewd);
            end
            chk($sformatf("v%0d i_rvalid", i), 32'(i_rvalid), 32'(tbl[i].irv));
            chk($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'(tbl[i].drv));
            chk($sformatf("v%0d i_done", i), 32'(i_done), 32'(tbl[i].idn));
            chk($sformatf("v%0d d_done", i), 32'(d_done), 32'(tbl[i].ddn));
            if (tbl[i].irv || tbl[i].drv)
                chk($sformatf("v%0d fill_idx", i), 32'(fill_idx), 32'(tbl[i].idx));
            chk($sformatf("v%0d stall_f", i), 32'(stall_f), 32'(tbl[i].sf));
            chk($sformatf("v%0d stall_m", i), 32'(stall_m), 32'(tbl[i].sm));
        end

        // Round-robin order from a fresh reset (last owner = I)
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        serve(H, H, "DI");
        serve(H, H, "DI");
        serve(H, L, "I");
        serve(H, H, "DI");

        // Reset during beat 2 of a D fill
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; i_req = 1'b0;
        mem_bus.mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("pre-reset fill_idx", 32'(fill_idx), 32'd2);
        chk("pre-reset d_rvalid", 32'(d_rvalid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; d_req = 1'b0;
        #1;
        chk("abort mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("abort d_done", 32'(d_done), 32'd0);
        chk("abort d_rvalid", 32'(d_rvalid), 32'd0);
        chk("abort mem_addr", mem_bus.mem_addr, Z);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h5678; mem_bus.mem_ready = 1'b0;
        #1;
        chk("post-abort idle mem_req", 32'(mem_bus.mem_req), 32'd0);
        chk("post-abort d_done", 32'(d_done), 32'd0);
        @(negedge clk);
        #1;
        chk("post-abort grant mem_req", 32'(mem_bus.mem_req), 32'd1);
        chk("post-abort mem_addr", mem_bus.mem_addr, 32'h5670);
        chk("post-abort stall_f", 32'(stall_f), 32'd1);
        mem_bus.mem_ready = 1'b1;
        seen = 1'b0;
        wait_cyc = 0;
        while (!seen && wait_cyc < 12) begin
            @(negedge clk);
            #1;
            if (i_done) seen = 1'b1;
            wait_cyc++;
        end
        chk("post-abort i_done seen", 32'(seen), 32'd1);
        chk("post-abort i_done latency", 32'(wait_cyc), 32'd4);
        i_req = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
